regfile_32x64: RTL and testbench
================================

Name: regfile_32x64

Overview:
- General-purpose register file for the ARM (LEGv8-style) single-cycle datapath: 32 entries x 64 bits.
- Two combinational read ports feed the ALU operand paths; one synchronous write port is used for writeback.
- Register 31 is the hard-wired zero register (XZR).

Parameters:
- DATA_WIDTH, 64, width of each register and of the data ports.
- ADDR_WIDTH, 5, width of the select inputs; the register count is 2**ADDR_WIDTH (32).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- ReadSelect1  input  ADDR_WIDTH  register index for read port 1.
- ReadSelect2  input  ADDR_WIDTH  register index for read port 2.
- WriteSelect  input  ADDR_WIDTH  register index for the write port.
- WriteData  input  DATA_WIDTH  data to write.
- WriteEnable  input  1  write strobe, active high.
- ReadData1  output  DATA_WIDTH  contents of the register selected by ReadSelect1.
- ReadData2  output  DATA_WIDTH  contents of the register selected by ReadSelect2.

Behaviour:
- Storage: 32 x DATA_WIDTH flops, indices 0..31.
- Reset:
  - rst=1 at a rising clk edge clears all 32 registers to 0.
  - Reset has priority over a write in the same cycle.
  - Read outputs are not forced during reset. They show the stored contents, which are 0 from the first reset edge onward.
- Write:
  - At a rising clk edge with rst=0, WriteEnable=1 and WriteSelect != 31, reg[WriteSelect] <= WriteData.
  - WriteEnable=0: no state changes.
  - WriteEnable X/Z must not corrupt state; only a clean 1 writes.
- Zero register:
  - Writes to index 31 are discarded.
  - Any read of index 31 returns 0 regardless of history.
- Read:
  - Purely combinational, zero latency.
  - ReadDataN = (ReadSelectN == 31) ? 0 : reg[ReadSelectN].
  - Both ports are fully independent and may select the same register; both then return the same value.
- Read-during-write (same index, same cycle):
  - The read returns the old value until the clock edge and the new value after it.
  - Exception: the bypass feature below.
- Mid-operation reset: asserting rst after writes clears every register on the next edge. Writes presented during reset are lost.
- No other outputs and no internal state beyond the register array.

Optional Feature:
- Macro: RF_BYPASS_EN.
- Defined: write-to-read forwarding. When WriteEnable=1, rst=0, WriteSelect != 31 and ReadSelectN == WriteSelect, ReadDataN combinationally equals WriteData in the same cycle, before the edge. The index-31 read still returns 0.
- Undefined: no forwarding. Reads always reflect the stored array contents.

Test Plan:
- Reset: hold rst=1 for 5 clk edges, ReadSelect1=0, ReadSelect2=31 -> ReadData1=0, ReadData2=0.
- Basic write/read: rst=0, WriteEnable=1, WriteSelect=0, WriteData=64'h1, one edge -> ReadData1 (sel 0) = 64'h1. Then WriteEnable=0 with WriteData=64'hFF for 5 edges -> ReadData1 stays 64'h1.
- Zero register: WriteEnable=1, WriteSelect=31, WriteData=64'hDEADBEEF, edge -> ReadData2 (sel 31) = 0.
- Full sweep: write reg[i]=i*64'h0101010101010101 for i=0..30, then read all pairs (i, 30-i) on both ports -> each matches its written value, index 31 reads 0, and same-index reads on both ports agree.
- Read-during-write: reg[5]=64'hA, then WriteEnable=1, WriteSelect=5, WriteData=64'hB, ReadSelect1=5:
  - Before the edge, ReadData1=64'hA, or 64'hB with RF_BYPASS_EN.
  - After the edge, ReadData1=64'hB.
- Reset priority and mid-operation reset: load reg[3]=64'h7, then rst=1 together with WriteEnable=1, WriteSelect=3, WriteData=64'h9, edge -> ReadData (sel 3) = 0. Release rst -> reg[3] remains 0 until rewritten.

Source files
------------

// File: rtl/regfile_32x64.sv
// 32 x 64-bit register file: two combinational read ports, one synchronous write port, index 31 reads as zero.
// Define RF_BYPASS_EN to forward same-cycle write data to matching read ports.
module regfile_32x64 #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] ReadSelect1,
  input  logic [ADDR_WIDTH-1:0] ReadSelect2,
  input  logic [ADDR_WIDTH-1:0] WriteSelect,
  input  logic [DATA_WIDTH-1:0] WriteData,
  input  logic                  WriteEnable,
  output logic [DATA_WIDTH-1:0] ReadData1,
  output logic [DATA_WIDTH-1:0] ReadData2
);

  localparam int NumRegs = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ZeroIdx = '1;

  logic [DATA_WIDTH-1:0] regArray [NumRegs];
  logic                  writeActive;

  // An unknown WriteEnable makes this unknown, which the if statements treat as false.
  assign writeActive = WriteEnable && !rst && (WriteSelect != ZeroIdx);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NumRegs; i++) begin
        regArray[i] <= '0;
      end
    end else if (writeActive) begin
      regArray[WriteSelect] <= WriteData;
    end
  end

  always_comb begin
    ReadData1 = regArray[ReadSelect1];
    ReadData2 = regArray[ReadSelect2];
`ifdef RF_BYPASS_EN
    if (writeActive && (ReadSelect1 == WriteSelect)) begin
      ReadData1 = WriteData;
    end
    if (writeActive && (ReadSelect2 == WriteSelect)) begin
      ReadData2 = WriteData;
    end
`endif
    if (ReadSelect1 == ZeroIdx) begin
      ReadData1 = '0;
    end
    if (ReadSelect2 == ZeroIdx) begin
      ReadData2 = '0;
    end
  end

endmodule

// File: tb/tb_regfile_32x64.sv
// Self-checking bench for regfile_32x64: directed scenarios plus randomized traffic
// compared against an array-based reference model.
module tb_regfile_32x64;

  logic        clk;
  logic        rst;
  logic [4:0]  ReadSelect1;
  logic [4:0]  ReadSelect2;
  logic [4:0]  WriteSelect;
  logic [63:0] WriteData;
  logic        WriteEnable;
  logic [63:0] ReadData1;
  logic [63:0] ReadData2;

  logic [63:0] model [32];
  int          checks;
  int          errors;
  logic [63:0] sweepStep;

  regfile_32x64 dut (
    .clk         (clk),
    .rst         (rst),
    .ReadSelect1 (ReadSelect1),
    .ReadSelect2 (ReadSelect2),
    .WriteSelect (WriteSelect),
    .WriteData   (WriteData),
    .WriteEnable (WriteEnable),
    .ReadData1   (ReadData1),
    .ReadData2   (ReadData2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic we, input logic [4:0] ws,
                               input logic [63:0] wd, input logic [4:0] rs1, input logic [4:0] rs2);
    rst         = r;
    WriteEnable = we;
    WriteSelect = ws;
    WriteData   = wd;
    ReadSelect1 = rs1;
    ReadSelect2 = rs2;
  endtask

  // Expected read value given the inputs currently being driven.
  function automatic logic [63:0] expRead(input logic [4:0] sel);
    if (sel == 5'd31) return 64'h0;
`ifdef RF_BYPASS_EN
    if (WriteEnable === 1'b1 && rst === 1'b0 && WriteSelect != 5'd31 && sel == WriteSelect)
      return WriteData;
`endif
    return model[sel];
  endfunction

  // Advance one clock edge, updating the model with the architectural rules.
  task automatic tick();
    if (rst === 1'b1) begin
      for (int i = 0; i < 32; i++) model[i] = 64'h0;
    end else if (WriteEnable === 1'b1 && WriteSelect != 5'd31) begin
      model[WriteSelect] = WriteData;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic checkBothPorts(input string tag);
    checkOutput({tag, "_rd1"}, ReadData1, expRead(ReadSelect1));
    checkOutput({tag, "_rd2"}, ReadData2, expRead(ReadSelect2));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 32; i++) model[i] = 64'h0;
    applyStimulus(1'b1, 1'b0, 5'd0, 64'h0, 5'd0, 5'd31);

    // Reset held for five edges.
    repeat (5) tick();
    checkOutput("reset_rd1", ReadData1, 64'h0);
    checkOutput("reset_rd2", ReadData2, 64'h0);

    // Basic write then hold with enable low.
    applyStimulus(1'b0, 1'b1, 5'd0, 64'h1, 5'd0, 5'd31);
    tick();
    checkOutput("basic_write", ReadData1, 64'h1);
    applyStimulus(1'b0, 1'b0, 5'd0, 64'hFF, 5'd0, 5'd31);
    repeat (5) tick();
    checkOutput("basic_hold", ReadData1, 64'h1);

    // Writes to the zero register are discarded.
    applyStimulus(1'b0, 1'b1, 5'd31, 64'hDEADBEEF, 5'd0, 5'd31);
    #1;
    checkOutput("xzr_pre", ReadData2, 64'h0);
    tick();
    checkOutput("xzr_post", ReadData2, 64'h0);

    // Full sweep.
    sweepStep = 64'h0101010101010101;
    for (int i = 0; i < 31; i++) begin
      applyStimulus(1'b0, 1'b1, 5'(i), sweepStep * 64'(i), 5'd0, 5'd0);
      tick();
    end
    WriteEnable = 1'b0;
    for (int i = 0; i < 31; i++) begin
      ReadSelect1 = 5'(i);
      ReadSelect2 = 5'(30 - i);
      #1;
      checkOutput($sformatf("sweep_rd1_%0d", i), ReadData1, sweepStep * 64'(i));
      checkOutput($sformatf("sweep_rd2_%0d", 30 - i), ReadData2, sweepStep * 64'(30 - i));
      ReadSelect2 = 5'(i);
      #1;
      checkOutput($sformatf("sweep_same_%0d", i), ReadData2, sweepStep * 64'(i));
    end
    ReadSelect1 = 5'd31;
    ReadSelect2 = 5'd31;
    #1;
    checkOutput("sweep_xzr_rd1", ReadData1, 64'h0);
    checkOutput("sweep_xzr_rd2", ReadData2, 64'h0);

    // Read-during-write on the same index.
    applyStimulus(1'b0, 1'b1, 5'd5, 64'hA, 5'd5, 5'd31);
    tick();
    applyStimulus(1'b0, 1'b1, 5'd5, 64'hB, 5'd5, 5'd5);
    #1;
`ifdef RF_BYPASS_EN
    checkOutput("rdw_pre", ReadData1, 64'hB);
`else
    checkOutput("rdw_pre", ReadData1, 64'hA);
`endif
    tick();
    checkOutput("rdw_post", ReadData1, 64'hB);

    // Reset priority over a same-cycle write, and state after release.
    applyStimulus(1'b0, 1'b1, 5'd3, 64'h7, 5'd3, 5'd3);
    tick();
    checkOutput("prio_load", ReadData1, 64'h7);
    applyStimulus(1'b1, 1'b1, 5'd3, 64'h9, 5'd3, 5'd5);
    tick();
    checkOutput("prio_rst_rd1", ReadData1, 64'h0);
    checkOutput("prio_rst_rd2", ReadData2, 64'h0);
    applyStimulus(1'b0, 1'b0, 5'd3, 64'h9, 5'd3, 5'd3);
    repeat (3) tick();
    checkOutput("prio_release", ReadData1, 64'h0);

    // Randomized traffic including unknown enables and occasional resets.
    for (int n = 0; n < 400; n++) begin
      int r;
      logic we;
      logic [4:0] ws;
      r  = $urandom_range(0, 9);
      we = (r == 0) ? 1'bx : ((r < 6) ? 1'b1 : 1'b0);
      ws = 5'($urandom_range(0, 31));
      applyStimulus(($urandom_range(0, 24) == 0), we, ws, {$urandom, $urandom},
                    ($urandom_range(0, 3) == 0) ? ws : 5'($urandom_range(0, 31)),
                    ($urandom_range(0, 3) == 0) ? ws : 5'($urandom_range(0, 31)));
      #1;
      checkBothPorts($sformatf("rand_pre_%0d", n));
      tick();
      checkBothPorts($sformatf("rand_post_%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
